sap_1_fetch_unit: RTL and testbench
===================================

Name: sap_1_fetch_unit

Overview:
- Bus-initiator side of the SAP-1 instruction ROM: sequences the six-state ring counter, holds the program counter, memory address register (MAR) and instruction register (IR).
- Drives the 4-bit ROM address and active-low chip enable, and captures the returned 8-bit word.
- Decodes the opcode into memory-reference, output and halt events for the accumulator/ALU datapath.

Parameters:
- RESET_PC, 4'h0, program counter value loaded on reset.
- HALT_OPCODE, 4'hF, opcode (IR[7:4]) that stops the ring counter.
- OUT_OPCODE, 4'hE, opcode that pulses out_strobe.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  reset; asynchronous, active-high.
- instruction_in  input  8  word returned by the ROM; only meaningful while CEbar=0.
- address_out  output  4  ROM address, equal to the MAR register.
- CEbar  output  1  ROM chip enable, active-low.
- opcode_out  output  4  IR[7:4].
- operand_out  output  4  IR[3:0].
- t_state  output  6  one-hot ring state; bit0=T1 ... bit5=T6.
- pc_out  output  4  current program counter.
- mem_data_valid  output  1  high during T5 of LDA/ADD/SUB; the datapath samples instruction_in on the closing edge.
- out_strobe  output  1  one-cycle pulse in T4 of OUT.
- halted  output  1  high once HLT has executed.

Behaviour:
- Reset (CLR=1, async, immediate, also mid-instruction):
  - PC=RESET_PC, MAR=0, IR=0, t_state=6'b000001 (T1).
  - CEbar=1, mem_data_valid=0, out_strobe=0, halted=0.
  - While CLR is high, clock edges are ignored.
- Ring counter:
  - Advances T1→T2→…→T6→T1, one state per CLK edge. Every instruction takes exactly 6 cycles.
  - HALT state is terminal; only CLR leaves it.
- T1 (address): on the closing edge, MAR<=PC.
- T2 (increment): on the closing edge, PC<=PC+1, modulo 16 (15 wraps to 0, no flag).
- T3 (memory):
  - CEbar=0 for the whole cycle.
  - On the closing edge, IR<=instruction_in.
- T4 (execute 1): decode IR[7:4].
  - 0x0/0x1/0x2 (LDA/ADD/SUB): on the closing edge, MAR<=IR[3:0].
  - OUT_OPCODE: out_strobe=1 for this cycle only.
  - HALT_OPCODE: the closing edge enters HALT instead of T5.
  - Any other opcode is a NOP through T4–T6.
- T5 (execute 2):
  - For LDA/ADD/SUB: CEbar=0 and mem_data_valid=1.
  - Otherwise CEbar=1.
- T6: idle. CEbar=1. The closing edge returns to T1.
- HALT state:
  - halted=1, t_state=6'b000000, CEbar=1, strobes 0.
  - PC, MAR and IR are frozen.
- Output decoding:
  - CEbar, mem_data_valid and out_strobe are decoded from the registered state and IR only. They do not depend on instruction_in.
  - CEbar is never low outside T3 or a memory-reference T5.
- address_out is stable for the entire cycle in which CEbar is low. MAR loads only at the T1 and T4 edges.

Test Plan:
- Reset and T1 entry:
  - Stimulus: assert CLR mid-cycle, then release.
  - Response: t_state=6'b000001 and CEbar=1 immediately. pc_out=0 from the first edge after release (the T1 edge) and through T2. address_out=0 from the T1 edge onward. pc_out=1 from the T2 edge onward.
- Full program, ROM = {0:0x09, 1:0x1A, 2:0xE0, 3:0xF0}:
  - Cycle 2: CEbar=0 with address_out=0. Cycle 3: opcode_out=0, operand_out=9.
  - Cycle 4: CEbar=0, address_out=9, mem_data_valid=1.
  - Cycle 10: address_out=0xA, mem_data_valid=1.
  - Cycle 15: out_strobe=1 for exactly one cycle.
  - From cycle 22: halted=1, t_state=0, CEbar stays 1 for 20 more cycles.
- PC wrap:
  - Stimulus: ROM all 0x30 (NOP).
  - Response: pc_out sequence 0,1,…,15,0 at 6-cycle spacing. No mem_data_valid or out_strobe. CEbar low only in T3.
- Async reset during a memory-reference T5:
  - Stimulus: pulse CLR while CEbar=0 and address_out=9.
  - Response: in the same timestep CEbar=1, mem_data_valid=0, MAR=0, t_state=T1, pc_out=RESET_PC.
- Reset out of HALT:
  - Stimulus: pulse CLR while halted=1.
  - Response: halted=0, execution restarts from address 0, same cycle timing as the full-program scenario.
- Parameter override:
  - Stimulus: RESET_PC=4'hD, HALT_OPCODE=4'h7, ROM[13]=0x70.
  - Response: the first fetch has address_out=0xD, and halted=1 from cycle 4.

Source files
------------

// File: rtl/sap_1_fetch_unit.sv
// sap_1_fetch_unit: SAP-1 ring counter with PC, MAR and IR driving the instruction ROM
module sap_1_fetch_unit #(
   parameter logic [3:0] RESET_PC    = 4'h0,
   parameter logic [3:0] HALT_OPCODE = 4'hF,
   parameter logic [3:0] OUT_OPCODE  = 4'hE
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic [7:0] instruction_in,
   output logic [3:0] address_out,
   output logic       CEbar,
   output logic [3:0] opcode_out,
   output logic [3:0] operand_out,
   output logic [5:0] t_state,
   output logic [3:0] pc_out,
   output logic       mem_data_valid,
   output logic       out_strobe,
   output logic       halted
);
   typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;
   state_t     state, state_next;
   logic [3:0] pc, mar;
   logic [7:0] ir;
   logic       is_halt, is_out, mem_ref;
   // HLT takes precedence so an overlapping opcode parameter still stops the machine
   assign is_halt = ir[7:4] == HALT_OPCODE;
   assign is_out  = (ir[7:4] == OUT_OPCODE) && !is_halt;
   assign mem_ref = (ir[7:4] <= 4'h2) && !is_halt;
   // ring counter register; reset parks it in T1
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) state <= T1;
      else     state <= state_next;
   end
   // ring sequence: six steps per instruction, HLT diverts T4 into the terminal state
   always_comb begin
      state_next = state;
      case (state)
         T1:      state_next = T2;
         T2:      state_next = T3;
         T3:      state_next = T4;
         T4:      state_next = is_halt ? HALT : T5;
         T5:      state_next = T6;
         T6:      state_next = T1;
         HALT:    state_next = HALT;
         default: state_next = T1;
      endcase
   end
   // PC/MAR/IR transfers: MAR loads at T1 and memory-reference T4 edges only
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         pc  <= RESET_PC;
         mar <= 4'h0;
         ir  <= 8'h00;
      end else begin
         pc  <= (state == T2) ? pc + 4'd1 : pc;
         mar <= (state == T1) ? pc : ((state == T4) && mem_ref) ? ir[3:0] : mar;
         ir  <= (state == T3) ? instruction_in : ir;
      end
   end
   // bus and event outputs come only from the registered state and IR
   always_comb begin
      t_state        = (state == HALT) ? 6'b000000 : 6'b000001 << state;
      mem_data_valid = (state == T5) && mem_ref;
      CEbar          = !((state == T3) || mem_data_valid);
      out_strobe     = (state == T4) && is_out;
      halted         = state == HALT;
   end
   assign address_out = mar;
   assign pc_out      = pc;
   assign opcode_out  = ir[7:4];
   assign operand_out = ir[3:0];
endmodule

// File: tb/tb_sap_1_fetch_unit.sv
// tb_sap_1_fetch_unit: randomized and directed checks of the SAP-1 fetch unit against a cycle model
module tb_sap_1_fetch_unit;
   logic       CLK = 1'b0, CLR = 1'b0, CLR_p = 1'b0;
   logic [7:0] instruction_in, instr_p, junk;
   logic [3:0] address_out, opcode_out, operand_out, pc_out;
   logic [3:0] addr_p, op_p, opr_p, pc_p;
   logic [5:0] t_state, t_p;
   logic       CEbar, mem_data_valid, out_strobe, halted;
   logic       ce_p, mdv_p, os_p, h_p;
   logic [7:0] rom [16];
   logic [7:0] rom_p [16];
   int         checks = 0, errors = 0;
   logic [3:0] lg_addr [128];
   logic [3:0] lg_pc [128];
   logic [3:0] lg_op [128];
   logic [3:0] lg_opr [128];
   logic [5:0] lg_t [128];
   logic       lg_ce [128];
   logic       lg_mdv [128];
   logic       lg_os [128];
   logic       lg_h [128];
   logic [25:0] obs;

   sap_1_fetch_unit dut (
      .CLK(CLK), .CLR(CLR), .instruction_in(instruction_in), .address_out(address_out),
      .CEbar(CEbar), .opcode_out(opcode_out), .operand_out(operand_out), .t_state(t_state),
      .pc_out(pc_out), .mem_data_valid(mem_data_valid), .out_strobe(out_strobe), .halted(halted)
   );

   sap_1_fetch_unit #(.RESET_PC(4'hD), .HALT_OPCODE(4'h7), .OUT_OPCODE(4'hE)) dut_p (
      .CLK(CLK), .CLR(CLR_p), .instruction_in(instr_p), .address_out(addr_p),
      .CEbar(ce_p), .opcode_out(op_p), .operand_out(opr_p), .t_state(t_p),
      .pc_out(pc_p), .mem_data_valid(mdv_p), .out_strobe(os_p), .halted(h_p)
   );

   always #5 CLK = ~CLK;
   always @(negedge CLK) junk <= 8'($urandom);
   assign instruction_in = CEbar ? junk : rom[address_out];
   assign instr_p        = ce_p ? junk : rom_p[addr_p];
   assign obs = {t_state, CEbar, mem_data_valid, out_strobe, halted, address_out, pc_out, opcode_out, operand_out};

   task automatic load_program();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'hE0; rom[3] = 8'hF0;
      rom[9] = 8'h55; rom[10] = 8'h22;
   endtask

   task automatic do_reset(input string tag);
      CLR = 1'b1;
      #1;
      checks++;
      if ({t_state, CEbar, mem_data_valid, out_strobe, halted} !== {6'b000001, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s immediate reset: got t=%b ce=%b mdv=%b os=%b h=%b", tag, t_state, CEbar, mem_data_valid, out_strobe, halted);
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({t_state, pc_out, address_out} !== {6'b000001, 4'h0, 4'h0}) begin
         errors++;
         $display("FAIL %s edge under reset: got t=%b pc=%h addr=%h expected t=000001 pc=0 addr=0", tag, t_state, pc_out, address_out);
      end
      CLR = 1'b0;
      #1;
   endtask

   // Cycle model: ph is the step within the 6-cycle instruction; register transfers follow the instruction rules.
   task automatic run_program(input int n, input string tag);
      logic [3:0]  m_pc, m_mar;
      logic [7:0]  m_ir;
      logic [25:0] expv;
      bit          m_h, mem;
      int          ph;
      m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_h = 0; ph = 0;
      for (int c = 0; c < n; c++) begin
         mem = m_ir[7:4] <= 4'h2;
         if (m_h) expv = {6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, m_mar, m_pc, m_ir};
         else expv = {6'(1 << ph), !(ph == 2 || (ph == 4 && mem)), ph == 4 && mem, ph == 3 && m_ir[7:4] == 4'hE, 1'b0, m_mar, m_pc, m_ir};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, expv);
         end
         if (c < 128) begin
            lg_addr[c] = address_out; lg_pc[c] = pc_out; lg_op[c] = opcode_out; lg_opr[c] = operand_out;
            lg_t[c] = t_state; lg_ce[c] = CEbar; lg_mdv[c] = mem_data_valid; lg_os[c] = out_strobe; lg_h[c] = halted;
         end
         if (!m_h) begin
            if (ph == 0) m_mar = m_pc;
            if (ph == 1) m_pc = m_pc + 4'd1;
            if (ph == 2) m_ir = rom[m_mar];
            if (ph == 3 && m_ir[7:4] == 4'hF) m_h = 1;
            else if (ph == 3 && mem) m_mar = m_ir[3:0];
            ph = (ph + 1) % 6;
         end
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      load_program();
      do_reset("reset");
      run_program(8, "reset_run");
      checks++;
      if ({lg_pc[1], lg_pc[2], lg_addr[1], lg_addr[2]} !== {4'h0, 4'h1, 4'h0, 4'h0}) begin
         errors++;
         $display("FAIL reset pc/addr: got pc1=%h pc2=%h addr1=%h addr2=%h expected 0 1 0 0", lg_pc[1], lg_pc[2], lg_addr[1], lg_addr[2]);
      end
   endtask

   task automatic test_full_program(input string tag);
      int os_count;
      bit halt_bad;
      load_program();
      do_reset(tag);
      run_program(42, tag);
      checks++;
      if ({lg_ce[2], lg_addr[2]} !== {1'b0, 4'h0}) begin
         errors++;
         $display("FAIL %s cycle2 fetch: got ce=%b addr=%h expected ce=0 addr=0", tag, lg_ce[2], lg_addr[2]);
      end
      checks++;
      if ({lg_op[3], lg_opr[3]} !== {4'h0, 4'h9}) begin
         errors++;
         $display("FAIL %s cycle3 IR: got %h%h expected 09", tag, lg_op[3], lg_opr[3]);
      end
      checks++;
      if ({lg_ce[4], lg_addr[4], lg_mdv[4]} !== {1'b0, 4'h9, 1'b1}) begin
         errors++;
         $display("FAIL %s cycle4 LDA read: got ce=%b addr=%h mdv=%b expected ce=0 addr=9 mdv=1", tag, lg_ce[4], lg_addr[4], lg_mdv[4]);
      end
      checks++;
      if ({lg_addr[10], lg_mdv[10]} !== {4'hA, 1'b1}) begin
         errors++;
         $display("FAIL %s cycle10 ADD read: got addr=%h mdv=%b expected addr=a mdv=1", tag, lg_addr[10], lg_mdv[10]);
      end
      os_count = 0;
      halt_bad = 0;
      for (int c = 0; c < 42; c++) begin
         os_count += int'(lg_os[c]);
         if (c >= 22 && {lg_h[c], lg_t[c], lg_ce[c]} !== {1'b1, 6'b000000, 1'b1}) halt_bad = 1;
      end
      checks++;
      if (lg_os[15] !== 1'b1 || os_count != 1) begin
         errors++;
         $display("FAIL %s out_strobe: got os15=%b count=%0d expected 1 and 1", tag, lg_os[15], os_count);
      end
      checks++;
      if (halt_bad) begin
         errors++;
         $display("FAIL %s halt hold: got halted/t_state/CEbar off during cycles 22..41, expected 1/0/1", tag);
      end
   endtask

   task automatic test_pc_wrap();
      int mdv_os;
      bit pc_bad, ce_bad;
      for (int i = 0; i < 16; i++) rom[i] = 8'h30;
      do_reset("wrap");
      run_program(100, "wrap");
      mdv_os = 0; pc_bad = 0; ce_bad = 0;
      for (int c = 0; c < 100; c++) begin
         mdv_os += int'(lg_mdv[c]) + int'(lg_os[c]);
         if (lg_ce[c] !== (c % 6 != 2)) ce_bad = 1;
      end
      for (int k = 0; k <= 16; k++) if (lg_pc[6 * k] !== 4'(k)) pc_bad = 1;
      checks++;
      if (pc_bad || mdv_os != 0 || ce_bad) begin
         errors++;
         $display("FAIL wrap: got pc_bad=%b strobes=%0d ce_bad=%b expected 0 0 0", pc_bad, mdv_os, ce_bad);
      end
   endtask

   task automatic test_reset_in_t5();
      load_program();
      do_reset("t5");
      run_program(4, "t5_pre");
      checks++;
      if ({CEbar, address_out, mem_data_valid} !== {1'b0, 4'h9, 1'b1}) begin
         errors++;
         $display("FAIL t5 precondition: got ce=%b addr=%h mdv=%b expected 0 9 1", CEbar, address_out, mem_data_valid);
      end
      CLR = 1'b1;
      #1;
      checks++;
      if ({CEbar, mem_data_valid, address_out, t_state, pc_out} !== {1'b1, 1'b0, 4'h0, 6'b000001, 4'h0}) begin
         errors++;
         $display("FAIL t5 async reset: got ce=%b mdv=%b addr=%h t=%b pc=%h", CEbar, mem_data_valid, address_out, t_state, pc_out);
      end
      @(negedge CLK);
      CLR = 1'b0;
      #1;
      run_program(24, "t5_restart");
   endtask

   task automatic test_reset_from_halt();
      load_program();
      do_reset("halt_pre");
      run_program(30, "halt_pre");
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt reached: got halted=%b expected 1", halted);
      end
      test_full_program("halt_restart");
   endtask

   task automatic test_random();
      for (int trial = 0; trial < 6; trial++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
         do_reset("random");
         run_program(150, $sformatf("random%0d", trial));
      end
   endtask

   task automatic test_param_override();
      for (int i = 0; i < 16; i++) rom_p[i] = 8'h30;
      rom_p[13] = 8'h70;
      CLR_p = 1'b1;
      #1;
      checks++;
      if ({t_p, pc_p} !== {6'b000001, 4'hD}) begin
         errors++;
         $display("FAIL param reset: got t=%b pc=%h expected 000001 d", t_p, pc_p);
      end
      @(negedge CLK);
      CLR_p = 1'b0;
      #1;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) begin
            checks++;
            if ({ce_p, addr_p} !== {1'b0, 4'hD}) begin
               errors++;
               $display("FAIL param fetch: got ce=%b addr=%h expected 0 d", ce_p, addr_p);
            end
         end
         if (c == 3) begin
            checks++;
            if ({op_p, h_p} !== {4'h7, 1'b0}) begin
               errors++;
               $display("FAIL param decode: got op=%h halted=%b expected 7 0", op_p, h_p);
            end
         end
         if (c >= 4) begin
            checks++;
            if ({h_p, t_p, ce_p, pc_p} !== {1'b1, 6'b000000, 1'b1, 4'hE}) begin
               errors++;
               $display("FAIL param halt cycle %0d: got h=%b t=%b ce=%b pc=%h expected 1 000000 1 e", c, h_p, t_p, ce_p, pc_p);
            end
         end
         @(negedge CLK);
         #1;
      end
   endtask

   initial begin
      @(negedge CLK);
      #1;
      test_reset();
      test_full_program("program");
      test_pc_wrap();
      test_reset_in_t5();
      test_reset_from_halt();
      test_random();
      test_param_override();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
